// File: rtl/stream_rr_arb.sv
// Round-robin packet arbiter merging NUM_SRC AXI-Stream style sources onto one sink.
// Optional feature: define STREAM_RR_ARB_PKT_CNT_EN to add the pkt_cnt completed-packet counter.
module stream_rr_arb #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_SRC = 4,
  localparam int IDW     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]       s_tvalid,
  input  logic [NUM_SRC-1:0]       s_tlast,
  output logic [NUM_SRC-1:0]       s_tready,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [IDW-1:0]           m_tid
`ifdef STREAM_RR_ARB_PKT_CNT_EN
  ,
  output logic [31:0]              pkt_cnt
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, grant_q, pick;
  logic [IDW:0]     cand;
  logic             found, lock, beat_done;
  logic [7:0]       valid_ext, last_ext, ready_ext;
  logic [WIDTH-1:0] data_arr [8];
  logic [WIDTH-1:0] data_hold_q;
  logic             last_hold_q;

  // Lanes are padded to the full 3-bit id space so grant_q indexes them without range issues.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    if (g < NUM_SRC) begin : g_src
      assign data_arr[g] = s_tdata[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign data_arr[g] = '0;
    end
  end

  assign valid_ext = 8'(s_tvalid);
  assign last_ext  = 8'(s_tlast);

  // Scan downward from ptr+NUM_SRC-1 so the last hit written is the one closest to ptr.
  // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_SRC)) cand = cand - (IDW+1)'(NUM_SRC);
      if (valid_ext[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  assign lock      = (state_q == LOCK);
  assign m_tvalid  = lock & valid_ext[grant_q];
  assign m_tdata   = lock ? data_arr[grant_q] : data_hold_q;
  assign m_tlast   = lock ? last_ext[grant_q] : last_hold_q;
  assign m_tid     = grant_q;
  assign beat_done = m_tvalid & m_tready & m_tlast;

  always_comb begin
    ready_ext = '0;
    if (lock) ready_ext[grant_q] = m_tready;
  end
  assign s_tready = ready_ext[NUM_SRC-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = LOCK;
      LOCK:    if (beat_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      data_hold_q <= '0;
      last_hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!lock && found) grant_q <= pick;
      if (beat_done) ptr_q <= (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + IDW'(1);
      // Idle outputs replay whatever was last presented while locked.
      if (lock) begin
        data_hold_q <= m_tdata;
        last_hold_q <= m_tlast;
      end
    end
  end

`ifdef STREAM_RR_ARB_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pkt_cnt <= '0;
    else if (beat_done) pkt_cnt <= pkt_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed self-checking bench for stream_rr_arb (WIDTH=32, NUM_SRC=4).
// Covers the optional pkt_cnt output when STREAM_RR_ARB_PKT_CNT_EN is defined.
module tb_stream_rr_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid, s_tlast, s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic [2:0]   m_tid;
`ifdef STREAM_RR_ARB_PKT_CNT_EN
  logic [31:0]  pkt_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stream_rr_arb #(.WIDTH(32), .NUM_SRC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_tid    (m_tid)
`ifdef STREAM_RR_ARB_PKT_CNT_EN
    ,
    .pkt_cnt  (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [31:0] d, input logic l);
    s_tdata[i*32 +: 32] = d;
    s_tvalid[i]         = v;
    s_tlast[i]          = l;
  endtask

  task automatic clear_srcs();
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
  endtask

  initial begin
    int beats, cycles;
    logic rdy;

    rst_n = 1'b0;
    clear_srcs();
    m_tready = 1'b1;
    #1;
    chk("reset_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("reset_s_tready", 32'(s_tready), 32'd0);
    chk("reset_m_tid",    32'(m_tid),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Single 3-beat packet from source 2: one bubble, then A0, A1, A2.
    set_src(2, 1'b1, 32'hA0, 1'b0);
    #1;
    chk("p2_bubble_valid",  32'(m_tvalid), 32'd0);
    chk("p2_bubble_ready",  32'(s_tready), 32'd0);
    tick();
    chk("p2_tid",           32'(m_tid),    32'd2);
    chk("p2_b0_valid",      32'(m_tvalid), 32'd1);
    chk("p2_b0_data",       m_tdata,       32'hA0);
    chk("p2_b0_ready",      32'(s_tready), 32'b0100);
    chk("p2_b0_last",       32'(m_tlast),  32'd0);
    tick();
    set_src(2, 1'b1, 32'hA1, 1'b0);
    #1;
    chk("p2_b1_data",       m_tdata,       32'hA1);
    tick();
    set_src(2, 1'b1, 32'hA2, 1'b1);
    #1;
    chk("p2_b2_data",       m_tdata,       32'hA2);
    chk("p2_b2_last",       32'(m_tlast),  32'd1);
    chk("p2_b2_tid",        32'(m_tid),    32'd2);
    tick();
    set_src(2, 1'b0, 32'h0, 1'b0);
    #1;
    chk("p2_idle_valid",    32'(m_tvalid), 32'd0);
    chk("p2_idle_hold",     m_tdata,       32'hA2);
    chk("p2_idle_tid_hold", 32'(m_tid),    32'd2);

    // All four sources saturated with 2-beat packets from a fresh pointer.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 32'(i*16), 1'b0);
    for (int p = 0; p < 5; p++) begin
      int g;
      g = p % 4;
      #1;
      chk("rr_bubble_valid", 32'(m_tvalid), 32'd0);
      tick();
      chk("rr_tid",     32'(m_tid),   32'(g));
      chk("rr_b0_data", m_tdata,      32'(g*16));
      chk("rr_b0_last", 32'(m_tlast), 32'd0);
      tick();
      set_src(g, 1'b1, 32'(g*16 + 1), 1'b1);
      #1;
      chk("rr_b1_data", m_tdata,      32'(g*16 + 1));
      chk("rr_b1_last", 32'(m_tlast), 32'd1);
      tick();
      set_src(g, 1'b1, 32'(g*16), 1'b0);
    end
    clear_srcs();

    // Source 1 stalls mid-packet while source 0 keeps requesting (pointer is now 1).
    set_src(1, 1'b1, 32'hB0, 1'b0);
    set_src(0, 1'b1, 32'hC0, 1'b1);
    tick();
    chk("stall_tid",  32'(m_tid), 32'd1);
    chk("stall_data", m_tdata,    32'hB0);
    tick();
    set_src(1, 1'b0, 32'hB1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 32'(m_tvalid), 32'd0);
      chk("stall_tid_c", 32'(m_tid),    32'd1);
      chk("stall_ready", 32'(s_tready), 32'b0010);
      tick();
    end
    set_src(1, 1'b1, 32'hB1, 1'b1);
    #1;
    chk("stall_resume_valid", 32'(m_tvalid), 32'd1);
    chk("stall_resume_data",  m_tdata,       32'hB1);
    tick();
    set_src(1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("stall_next_tid", 32'(m_tid),   32'd0);
    chk("stall_next_data", m_tdata,     32'hC0);
    tick();
    clear_srcs();

    // Source 3, 4 beats, sink ready toggling 1,0,1,0,... (pointer is now 1).
    set_src(3, 1'b1, 32'hD0, 1'b0);
    tick();
    chk("bp_tid", 32'(m_tid), 32'd3);
    beats  = 0;
    cycles = 0;
    rdy    = 1'b1;
    while (beats < 4 && cycles < 20) begin
      m_tready = rdy;
      set_src(3, 1'b1, 32'(32'hD0 + beats), beats == 3);
      #1;
      chk("bp_data",  m_tdata,       32'(32'hD0 + beats));
      chk("bp_ready", 32'(s_tready), {28'd0, rdy, 3'b000});
      tick();
      if (rdy) beats++;
      rdy = ~rdy;
      cycles++;
    end
    chk("bp_cycles", 32'(cycles), 32'd7);
    m_tready = 1'b1;
    set_src(3, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_done_valid", 32'(m_tvalid), 32'd0);
    chk("bp_done_hold",  m_tdata,       32'hD3);

    // Single-beat packet from 2 moves the pointer to 3, then reset mid-packet from 3.
    set_src(2, 1'b1, 32'hE2, 1'b1);
    tick();
    chk("single_tid",  32'(m_tid),   32'd2);
    chk("single_last", 32'(m_tlast), 32'd1);
    tick();
    set_src(2, 1'b0, 32'h0, 1'b0);
    set_src(3, 1'b1, 32'hE3, 1'b0);
    #1;
    chk("single_done_valid", 32'(m_tvalid), 32'd0);
    tick();
    chk("mid_tid", 32'(m_tid), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_tvalid), 32'd0);
    chk("async_rst_ready", 32'(s_tready), 32'd0);
    chk("async_rst_tid",   32'(m_tid),    32'd0);
    set_src(0, 1'b1, 32'hF0, 1'b1);
    tick();
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_valid", 32'(m_tvalid), 32'd0);
    tick();
    chk("post_rst_tid",  32'(m_tid), 32'd0);
    chk("post_rst_data", m_tdata,    32'hF0);
    tick();
    clear_srcs();

    // Ten single-beat packets from source 1 after a clean reset.
    #2 rst_n = 1'b0;
    #1;
`ifdef STREAM_RR_ARB_PKT_CNT_EN
    chk("cnt_reset", pkt_cnt, 32'd0);
`endif
    #2 rst_n = 1'b1;
    set_src(1, 1'b1, 32'h51, 1'b1);
    for (int p = 0; p < 10; p++) begin
      tick();
      chk("cnt_pkt_tid", 32'(m_tid), 32'd1);
      tick();
    end
    set_src(1, 1'b0, 32'h0, 1'b0);
    #1;
`ifdef STREAM_RR_ARB_PKT_CNT_EN
    chk("cnt_ten", pkt_cnt, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("cnt_cleared", pkt_cnt, 32'd0);
    #2 rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
